// File: rtl/monitor_sequencia.sv
// Receive-side checker for a one-hot ring sequence: decodes each sample, locks onto the rotation,
// flags illegal codes and broken steps, and keeps saturating lap/error counters. Outputs registered, 1-cycle latency.
module monitor_sequencia #(
  parameter int NBITS  = 4,
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valido,
  input  logic [NBITS-1:0]         Entrada,
  output logic [$clog2(NBITS)-1:0] indice,
  output logic                     indice_valido,
  output logic                     travado,
  output logic                     erro,
  output logic [CNT_W-1:0]         voltas,
  output logic [CNT_W-1:0]         erros
);

  localparam int IW = $clog2(NBITS);
  localparam int CW = $clog2(LOCK_N + 1);
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  typedef enum logic [1:0] {BUSCA, SINC, TRAVADO} estado_t;

  estado_t          state_q, state_d;
  logic [CW-1:0]    conf_q, conf_d;
  logic [NBITS-1:0] anterior_q, anterior_d;
  logic [IW-1:0]    indice_q, indice_d;
  logic             iv_q, iv_d;
  logic             erro_q, erro_d;
  logic [CNT_W-1:0] voltas_q, voltas_d;
  logic [CNT_W-1:0] erros_q, erros_d;

  logic             is_zero, is_legal, is_ilegal, is_match, is_restart;
  logic             lap;
  logic [NBITS-1:0] esperado;
  logic [IW-1:0]    idx;

  // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves nothing.
  assign is_zero    = (Entrada == '0);
  assign is_legal   = !is_zero && ((Entrada & (Entrada - ONE)) == '0);
  assign is_ilegal  = !is_zero && !is_legal;
  assign esperado   = {anterior_q[NBITS-2:0], anterior_q[NBITS-1]};
  assign is_match   = is_legal && (Entrada == esperado);
  assign is_restart = is_legal && !is_match && (Entrada == ONE);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (Entrada[i]) idx = IW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    conf_d     = conf_q;
    anterior_d = anterior_q;
    indice_d   = indice_q;
    iv_d       = 1'b0;
    erro_d     = 1'b0;
    lap        = 1'b0;
    if (valido) begin
      if (is_legal) begin
        indice_d   = idx;
        iv_d       = 1'b1;
        anterior_d = Entrada;
      end else begin
        anterior_d = '0;
      end
      case (state_q)
        BUSCA: begin
          if (is_legal) begin
            state_d = SINC;
            conf_d  = CW'(1);
          end else if (is_ilegal) begin
            erro_d = 1'b1;
          end
        end
        SINC, TRAVADO: begin
          if (is_zero || is_ilegal) begin
            state_d = BUSCA;
            conf_d  = '0;
            erro_d  = is_ilegal;
          end else if (is_match) begin
            if (state_q == TRAVADO) begin
              lap = anterior_q[NBITS-1];
            end else begin
              conf_d = conf_q + CW'(1);
              if (conf_q == CW'(LOCK_N - 1)) state_d = TRAVADO;
            end
          end else begin
            // RESTART is the sequencer's parallel load, so it resyncs without an error.
            state_d = SINC;
            conf_d  = CW'(1);
            erro_d  = !is_restart;
          end
        end
        default: begin
          state_d = BUSCA;
          conf_d  = '0;
        end
      endcase
    end
    voltas_d = (lap && voltas_q != '1) ? voltas_q + CNT_W'(1) : voltas_q;
    erros_d  = (erro_d && erros_q != '1) ? erros_q + CNT_W'(1) : erros_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BUSCA;
      conf_q     <= '0;
      anterior_q <= '0;
      indice_q   <= '0;
      iv_q       <= 1'b0;
      erro_q     <= 1'b0;
      voltas_q   <= '0;
      erros_q    <= '0;
    end else begin
      state_q    <= state_d;
      conf_q     <= conf_d;
      anterior_q <= anterior_d;
      indice_q   <= indice_d;
      iv_q       <= iv_d;
      erro_q     <= erro_d;
      voltas_q   <= voltas_d;
      erros_q    <= erros_d;
    end
  end

  assign indice        = indice_q;
  assign indice_valido = iv_q;
  assign travado       = (state_q == TRAVADO);
  assign erro          = erro_q;
  assign voltas        = voltas_q;
  assign erros         = erros_q;

endmodule

// File: tb/tb_monitor_sequencia.sv
// Directed bench for monitor_sequencia: a default instance (CNT_W=8) and a CNT_W=2 instance
// share the same stimulus so saturation can be observed on the small one.
module tb_monitor_sequencia;

  logic       clk = 1'b0;
  logic       reset;
  logic       valido;
  logic [3:0] Entrada;

  logic [1:0] indice_a, indice_b;
  logic       iv_a, iv_b, trav_a, trav_b, erro_a, erro_b;
  logic [7:0] voltas_a, erros_a;
  logic [1:0] voltas_b, erros_b;

  int n_tests = 0;
  int n_fail  = 0;

  monitor_sequencia #(.NBITS(4), .CNT_W(8), .LOCK_N(3)) dut_a (
    .clk(clk), .reset(reset), .valido(valido), .Entrada(Entrada),
    .indice(indice_a), .indice_valido(iv_a), .travado(trav_a), .erro(erro_a),
    .voltas(voltas_a), .erros(erros_a)
  );

  monitor_sequencia #(.NBITS(4), .CNT_W(2), .LOCK_N(3)) dut_b (
    .clk(clk), .reset(reset), .valido(valido), .Entrada(Entrada),
    .indice(indice_b), .indice_valido(iv_b), .travado(trav_b), .erro(erro_b),
    .voltas(voltas_b), .erros(erros_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] e);
    @(negedge clk);
    valido  = v;
    Entrada = e;
    @(posedge clk);
    #1;
  endtask

  // Checks the decode/state outputs of the default instance in one call.
  task automatic chk_a(input string tag, input int idx, input int iv, input int trav, input int er);
    chk({tag, ".indice"}, indice_a, idx);
    chk({tag, ".iv"}, iv_a, iv);
    chk({tag, ".travado"}, trav_a, trav);
    chk({tag, ".erro"}, erro_a, er);
  endtask

  initial begin
    reset   = 1'b1;
    valido  = 1'b0;
    Entrada = 4'd0;
    step(1, 4'd2);
    step(1, 4'd4);
    chk_a("rst", 0, 0, 0, 0);
    chk("rst.voltas", voltas_a, 0);
    chk("rst.erros", erros_a, 0);
    reset = 1'b0;

    // Lock onto 1,2,4 then complete one lap 8 -> 1.
    step(1, 4'd1); chk_a("s1", 0, 1, 0, 0);
    step(1, 4'd2); chk_a("s2", 1, 1, 0, 0);
    step(1, 4'd4); chk_a("s4", 2, 1, 1, 0);
    step(1, 4'd8); chk_a("s8", 3, 1, 1, 0);
    chk("s8.voltas", voltas_a, 0);
    step(1, 4'd1); chk_a("lap1", 0, 1, 1, 0);
    chk("lap1.voltas", voltas_a, 1);
    step(1, 4'd2); chk_a("s2b", 1, 1, 1, 0);
    chk("s2b.erros", erros_a, 0);

    // Broken step 2 -> 8; the following 8 -> 1 happens in SINC and is no lap.
    step(1, 4'd8); chk_a("quebra", 3, 1, 0, 1);
    chk("quebra.erros", erros_a, 1);
    step(1, 4'd1); chk_a("q.s1", 0, 1, 0, 0);
    chk("q.s1.voltas", voltas_a, 1);
    step(1, 4'd2);
    step(1, 4'd4); chk_a("q.relock", 2, 1, 1, 0);

    // Restart (parallel load) from 4: no error, resync needed.
    step(1, 4'd1); chk_a("restart", 0, 1, 0, 0);
    chk("restart.erros", erros_a, 1);
    step(1, 4'd2); chk_a("r.s2", 1, 1, 0, 0);
    step(1, 4'd4); chk_a("r.relock", 2, 1, 1, 0);
    chk("r.voltas", voltas_a, 1);

    // Illegal code while locked: indice holds, no indice_valido.
    step(1, 4'b0110); chk_a("ilegal", 2, 0, 0, 1);
    chk("ilegal.erros", erros_a, 2);
    step(1, 4'd1);
    step(1, 4'd2);
    step(1, 4'd4); chk_a("i.relock", 2, 1, 1, 0);

    // Zero drops lock without an error.
    step(1, 4'd0); chk_a("zero", 2, 0, 0, 0);
    chk("zero.erros", erros_a, 2);
    step(1, 4'd1);
    step(1, 4'd2);
    step(1, 4'd4); chk_a("z.relock", 2, 1, 1, 0);

    // valido low: everything holds, no pulses, even with garbage on the bus.
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b1011);
      chk_a("hold", 2, 0, 1, 0);
    end
    chk("hold.voltas", voltas_a, 1);
    chk("hold.erros", erros_a, 2);

    // Three illegal codes: erros 2 -> 5 on A, saturates at 3 on B.
    step(1, 4'b0011); chk("e3.erro", erro_a, 1);
    step(1, 4'b0011); chk("e4.erro", erro_b, 1);
    step(1, 4'b0011);
    chk("esat.erros_a", erros_a, 5);
    chk("esat.erros_b", erros_b, 3);
    chk("esat.erro_b", erro_b, 1);

    // Relock and run 5 laps: voltas 1 -> 6 on A, saturates at 3 on B.
    step(1, 4'd1);
    step(1, 4'd2);
    step(1, 4'd4);
    for (int l = 0; l < 5; l++) begin
      step(1, 4'd8);
      step(1, 4'd1);
      step(1, 4'd2);
      step(1, 4'd4);
    end
    chk("lsat.voltas_a", voltas_a, 6);
    chk("lsat.voltas_b", voltas_b, 3);
    chk("lsat.travado_b", trav_b, 1);

    // Reset mid-lap with a lap-completing sample on the same edge: sample ignored.
    step(1, 4'd8);
    reset = 1'b1;
    step(1, 4'd1);
    chk_a("mrst", 0, 0, 0, 0);
    chk("mrst.voltas_a", voltas_a, 0);
    chk("mrst.erros_a", erros_a, 0);
    chk("mrst.voltas_b", voltas_b, 0);
    chk("mrst.erros_b", erros_b, 0);
    reset = 1'b0;

    // A legal sample after reset is decoded normally from BUSCA.
    step(1, 4'd2); chk_a("post", 1, 1, 0, 0);
    step(0, 4'd0); chk_a("post.idle", 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
